// File: rtl/wait_state_data_memory.sv
// Data-memory responder with LATENCY wait states before each one-cycle Ack.
// Define DMEM_RANDOM_WAIT_EN to add 0..3 LFSR-chosen extra wait cycles per request.
module wait_state_data_memory #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  WriteEnable,
    input  logic                  ReadEnable,
    input  logic [3:0]            ByteEnable,
    output logic                  Ack,
    output logic [DATA_WIDTH-1:0] ReadData
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} stateT;

    stateT                 state, stateNext;
    logic [4:0]            waitCnt, waitCntNext, loadCnt;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] reqAddr, curAddr;
    logic [DATA_WIDTH-1:0] reqData, curData, storedWord, mergedWord;
    logic [3:0]            reqBe, curBe;
    logic                  reqWrite, reqRead, curWrite, curRead;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  addrUnused;

    // Upper address bits alias modulo the depth; byte offset is ignored.
    assign addrUnused = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

`ifdef DMEM_RANDOM_WAIT_EN
    logic [7:0] lfsr;

    assign loadCnt = 5'(LATENCY - 1) + {3'b000, lfsr[1:0]};

    always_ff @(posedge CLK) begin
        if (!RST) begin
            lfsr <= 8'hA5;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`else
    assign loadCnt = 5'(LATENCY - 1);
`endif

    // In IDLE the live inputs are the request (LATENCY==1 enters ACK on the accept edge).
    always_comb begin
        if (state == IDLE) begin
            curAddr  = Address[ADDR_WIDTH+1:2];
            curData  = WriteData;
            curBe    = ByteEnable;
            curWrite = WriteEnable;
            curRead  = ReadEnable;
        end else begin
            curAddr  = reqAddr;
            curData  = reqData;
            curBe    = reqBe;
            curWrite = reqWrite;
            curRead  = reqRead;
        end
    end

    always_comb begin
        storedWord = mem[curAddr];
        mergedWord = storedWord;
        for (int unsigned i = 0; i < 4; i++) begin
            if (curBe[i]) mergedWord[8*i +: 8] = curData[8*i +: 8];
        end
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (ReadEnable || WriteEnable) begin
                    accept      = 1'b1;
                    waitCntNext = loadCnt;
                    stateNext   = (loadCnt == 5'd0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!(ReadEnable || WriteEnable)) begin
                    stateNext   = IDLE;
                    waitCntNext = '0;
                end else if (waitCnt <= 5'd1) begin
                    stateNext   = ACK;
                    waitCntNext = '0;
                end else begin
                    waitCntNext = waitCnt - 5'd1;
                end
            end
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign Ack = (state == ACK);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            waitCnt  <= '0;
            ReadData <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (stateNext == ACK && curRead) begin
                ReadData <= curWrite ? mergedWord : storedWord;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            reqAddr  <= Address[ADDR_WIDTH+1:2];
            reqData  <= WriteData;
            reqBe    <= ByteEnable;
            reqWrite <= WriteEnable;
            reqRead  <= ReadEnable;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST && state == ACK && reqWrite) begin
            mem[reqAddr] <= mergedWord;
        end
    end

endmodule

// File: tb/tb_wait_state_data_memory.sv
// Directed self-checking bench for wait_state_data_memory (LATENCY=2 and LATENCY=4 instances).
module tb_wait_state_data_memory;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        we2 = 1'b0, re2 = 1'b0, we4 = 1'b0, re4 = 1'b0;
    logic        ack2, ack4;
    logic [31:0] rd2, rd4;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    wait_state_data_memory #(.ADDR_WIDTH(10), .LATENCY(2), .DATA_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .Address(addr), .WriteData(wdata),
        .WriteEnable(we2), .ReadEnable(re2), .ByteEnable(be),
        .Ack(ack2), .ReadData(rd2)
    );

    wait_state_data_memory #(.ADDR_WIDTH(10), .LATENCY(4), .DATA_WIDTH(32)) dutL4 (
        .CLK(CLK), .RST(RST), .Address(addr), .WriteData(wdata),
        .WriteEnable(we4), .ReadEnable(re4), .ByteEnable(be),
        .Ack(ack4), .ReadData(rd4)
    );

    // Called and returns at posedge+1; leaves the selected DUT back in IDLE.
    task automatic doAccess(input bit sel4, input bit wr, input bit rd,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                            output int lat, output logic [31:0] rdata, output logic ackAfter);
        addr = a; wdata = d; be = b;
        if (sel4) begin we4 = wr; re4 = rd; end
        else begin we2 = wr; re2 = rd; end
        @(posedge CLK); lat = 1; #1;
        while (!(sel4 ? ack4 : ack2) && lat < 40) begin
            @(posedge CLK); lat++; #1;
        end
        if (!(sel4 ? ack4 : ack2)) lat = -1;
        rdata = sel4 ? rd4 : rd2;
        we2 = 0; re2 = 0; we4 = 0; re4 = 0;
        @(posedge CLK); #1;
        ackAfter = sel4 ? ack4 : ack2;
    endtask

    task automatic test_reset();
        RST = 0; we2 = 0; re2 = 0; we4 = 0; re4 = 0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack2); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rd2); end
        checks++; if (ack4 !== 1'b0) begin errors++; $display("FAIL reset_ack4: got %b expected 0", ack4); end
        RST = 1;
        @(posedge CLK); #1;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] r; logic aa;
        doAccess(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, lat, r, aa);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        checks++; if (aa !== 1'b0) begin errors++; $display("FAIL wr_ack_width: got %b expected 0", aa); end
        doAccess(0, 0, 1, 32'h10, 32'h0, 4'h0, lat, r, aa);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", r); end
        checks++; if (aa !== 1'b0) begin errors++; $display("FAIL rd_ack_width: got %b expected 0", aa); end
    endtask

    task automatic test_partial_store();
        int lat; logic [31:0] r; logic aa;
        doAccess(0, 1, 0, 32'h20, 32'h11223344, 4'hF, lat, r, aa);
        doAccess(0, 1, 0, 32'h20, 32'hAABBCCDD, 4'b0101, lat, r, aa);
        doAccess(0, 0, 1, 32'h20, 32'h0, 4'h0, lat, r, aa);
        checks++; if (r !== 32'h11BB33DD) begin errors++; $display("FAIL partial_store: got %h expected 11bb33dd", r); end
    endtask

    task automatic test_be_zero();
        int lat; logic [31:0] r; logic aa;
        doAccess(0, 1, 0, 32'h20, 32'hFFFFFFFF, 4'h0, lat, r, aa);
        checks++; if (lat !== 2) begin errors++; $display("FAIL be_zero_ack: got %0d expected 2", lat); end
        doAccess(0, 0, 1, 32'h20, 32'h0, 4'h0, lat, r, aa);
        checks++; if (r !== 32'h11BB33DD) begin errors++; $display("FAIL be_zero_data: got %h expected 11bb33dd", r); end
    endtask

    task automatic test_read_write_both();
        int lat; logic [31:0] r; logic aa;
        doAccess(0, 1, 0, 32'h24, 32'h01020304, 4'hF, lat, r, aa);
        doAccess(0, 1, 1, 32'h24, 32'hA0B0C0D0, 4'b1100, lat, r, aa);
        checks++; if (r !== 32'hA0B00304) begin errors++; $display("FAIL rw_merged_data: got %h expected a0b00304", r); end
        doAccess(0, 0, 1, 32'h24, 32'h0, 4'h0, lat, r, aa);
        checks++; if (r !== 32'hA0B00304) begin errors++; $display("FAIL rw_stored: got %h expected a0b00304", r); end
    endtask

    task automatic test_back_to_back();
        int lat, gap; logic [31:0] r; logic aa;
        doAccess(0, 1, 0, 32'h14, 32'h14141414, 4'hF, lat, r, aa);
        addr = 32'h10; re2 = 1;
        @(posedge CLK); lat = 1; #1;
        while (!ack2 && lat < 40) begin @(posedge CLK); lat++; #1; end
        checks++; if (lat !== 2 || ack2 !== 1'b1) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 2", lat); end
        checks++; if (rd2 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_first_data: got %h expected deadbeef", rd2); end
        addr = 32'h14;
        gap = 0;
        do begin @(posedge CLK); gap++; #1; end while (!ack2 && gap < 40);
        checks++; if (gap !== 3) begin errors++; $display("FAIL b2b_gap: got %0d expected 3", gap); end
        checks++; if (rd2 !== 32'h14141414) begin errors++; $display("FAIL b2b_second_data: got %h expected 14141414", rd2); end
        re2 = 0;
        repeat (2) begin @(posedge CLK); #1; end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] r; logic aa;
        doAccess(0, 1, 0, 32'h0000_1010, 32'hCAFEF00D, 4'hF, lat, r, aa);
        doAccess(0, 0, 1, 32'h13, 32'h0, 4'h0, lat, r, aa);
        checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL addr_wrap: got %h expected cafef00d", r); end
    endtask

    task automatic test_abort();
        int lat, ackSeen; logic [31:0] r; logic aa;
        addr = 32'h30; re4 = 1;
        @(posedge CLK); #1;
        re4 = 0;
        ackSeen = 0;
        repeat (10) begin @(posedge CLK); #1; if (ack4) ackSeen++; end
        checks++; if (ackSeen !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks expected 0", ackSeen); end
        checks++; if (rd4 !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 00000000", rd4); end
        doAccess(1, 1, 0, 32'h30, 32'h00000055, 4'hF, lat, r, aa);
        checks++; if (lat !== 4) begin errors++; $display("FAIL abort_wr_latency: got %0d expected 4", lat); end
        doAccess(1, 0, 1, 32'h30, 32'h0, 4'h0, lat, r, aa);
        checks++; if (r !== 32'h00000055) begin errors++; $display("FAIL abort_rd_data: got %h expected 00000055", r); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL abort_rd_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [31:0] r; logic aa;
        doAccess(0, 1, 0, 32'h40, 32'h0BADF00D, 4'hF, lat, r, aa);
        doAccess(0, 0, 1, 32'h40, 32'h0, 4'h0, lat, r, aa);
        addr = 32'h40; wdata = 32'h12345678; be = 4'hF; we2 = 1;
        @(posedge CLK); #1;
        RST = 0;
        @(posedge CLK); #1;
        checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL rst_wait_ack: got %b expected 0", ack2); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL rst_wait_rdata: got %h expected 00000000", rd2); end
        RST = 1; we2 = 0;
        @(posedge CLK); #1;
        doAccess(0, 0, 1, 32'h40, 32'h0, 4'h0, lat, r, aa);
        checks++; if (r !== 32'h0BADF00D) begin errors++; $display("FAIL rst_wait_mem: got %h expected 0badf00d", r); end
    endtask

    task automatic test_reset_in_ack();
        int lat; logic [31:0] r; logic aa;
        doAccess(0, 1, 0, 32'h44, 32'h11111111, 4'hF, lat, r, aa);
        addr = 32'h44; wdata = 32'h22222222; be = 4'hF; we2 = 1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checks++; if (ack2 !== 1'b1) begin errors++; $display("FAIL rst_ack_reached: got %b expected 1", ack2); end
        RST = 0;
        @(posedge CLK); #1;
        RST = 1; we2 = 0;
        checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL rst_ack_cleared: got %b expected 0", ack2); end
        @(posedge CLK); #1;
        doAccess(0, 0, 1, 32'h44, 32'h0, 4'h0, lat, r, aa);
        checks++; if (r !== 32'h11111111) begin errors++; $display("FAIL rst_ack_mem: got %h expected 11111111", r); end
    endtask

    task automatic test_latency_sequence();
        int lat; logic [31:0] r; logic aa;
        int latA[8];
        int latB[8];
        RST = 0;
        repeat (2) @(posedge CLK);
        #1; RST = 1;
        @(posedge CLK); #1;
        for (int i = 0; i < 8; i++) begin
            doAccess(0, 0, 1, 32'h10, 32'h0, 4'h0, lat, r, aa);
            latA[i] = lat;
        end
        RST = 0;
        repeat (2) @(posedge CLK);
        #1; RST = 1;
        @(posedge CLK); #1;
        for (int i = 0; i < 8; i++) begin
            doAccess(0, 0, 1, 32'h10, 32'h0, 4'h0, lat, r, aa);
            latB[i] = lat;
        end
        for (int i = 0; i < 8; i++) begin
`ifdef DMEM_RANDOM_WAIT_EN
            checks++; if (latA[i] < 2 || latA[i] > 5) begin errors++; $display("FAIL rand_latency_range[%0d]: got %0d expected 2..5", i, latA[i]); end
            checks++; if (latB[i] !== latA[i]) begin errors++; $display("FAIL rand_latency_repeat[%0d]: got %0d expected %0d", i, latB[i], latA[i]); end
`else
            checks++; if (latA[i] !== 2) begin errors++; $display("FAIL seq_latency[%0d]: got %0d expected 2", i, latA[i]); end
            checks++; if (latB[i] !== 2) begin errors++; $display("FAIL seq_latency_rerun[%0d]: got %0d expected 2", i, latB[i]); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_store();
        test_be_zero();
        test_read_write_both();
        test_back_to_back();
        test_wrap();
        test_abort();
        test_reset_mid_write();
        test_reset_in_ack();
        test_latency_sequence();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wait_state_data_memory.md
Name: wait_state_data_memory

Overview:
Data-memory responder for the core's D-memory port, with a programmable number of wait states before each Ack. It sits at the memory end of the core's load/store handshake: enables, address and byte enables come in; Ack and ReadData go back. It stresses the core's stall logic against slow memory and drops into the board top in place of the zero-wait data memory.

Parameters:
ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH 32-bit words
LATENCY, 2, cycles from request acceptance to Ack; legal range 1..15
DATA_WIDTH, 32, data bus width; fixed at 32, byte enables are 4 bits

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, synchronous, active-low
Address  input  32  byte address; word index = Address[ADDR_WIDTH+1:2]; Address[1:0] ignored
WriteData  input  32  store data, byte lanes selected by ByteEnable
WriteEnable  input  1  store request
ReadEnable  input  1  load request
ByteEnable  input  4  bit i enables byte lane [8i+7:8i] on writes
Ack  output  1  one-cycle completion pulse
ReadData  output  32  load data, valid in the Ack cycle and held until the next read Ack

Behaviour:
- Reset: CLK edge with RST==0 gives state=IDLE, Ack=0, ReadData=0, wait counter=0.
- Memory array is not cleared by reset.
- FSM states: IDLE, WAIT, ACK.
- IDLE: if ReadEnable|WriteEnable, latch the request (address, data, byte enables, kind).
  - Load counter with LATENCY-1.
  - LATENCY==1: go directly to ACK. Otherwise go to WAIT.
- WAIT: decrement counter each cycle; at 0 go to ACK.
- ACK: Ack=1 for exactly this one cycle.
  - Write: merge latched WriteData into the addressed word per byte-enable lane, committed at the end of this cycle.
  - Read: ReadData = stored word, registered on entry to ACK.
  - Next state is always IDLE.
- Ack timing: Ack rises exactly LATENCY cycles after the accepting IDLE edge.
- Initiator rule: the core holds enables, address and data stable until it samples Ack.
- Abort: if both enables drop while in WAIT, return to IDLE with no Ack and no memory update.
- Back-to-back: in the cycle after ACK, state is IDLE. Enables still high there count as a new request. Minimum per-access cost is LATENCY+1 cycles.
- ReadEnable and WriteEnable both high: treated as a write. ReadData returns the merged post-write word with the same Ack.
- ByteEnable==4'b0000 on a write: no bytes change, Ack still issued.
- Address wrap: upper bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo the depth.
- Reset mid-operation: RST==0 in WAIT or ACK returns to IDLE with Ack=0. A pending write is discarded; a write in the ACK cycle with RST==0 is not committed.
- Request signals are sampled only in IDLE. Changes during WAIT, other than the abort case, are ignored.

Optional Feature:
- Macro DMEM_RANDOM_WAIT_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and advances once per accepted request.
  - Its two LSBs add 0..3 extra wait cycles to LATENCY for that request.
  - The Ack cycle becomes LATENCY + lfsr[1:0] after acceptance.
  - Sequence is deterministic after reset.
- Undefined: no LFSR logic; latency is exactly LATENCY.

Test Plan:
1. LATENCY=2, after reset write Address=0x10, WriteData=0xDEADBEEF, ByteEnable=4'hF -> Ack high exactly 2 cycles after the accept edge, for one cycle. Then read 0x10 -> ReadData=0xDEADBEEF with Ack.
2. Partial store: preload word 0x20 with 0x11223344, write 0xAABBCCDD with ByteEnable=4'b0101 -> subsequent read returns 0x11BB33DD.
3. Abort: assert ReadEnable at 0x30, drop it after 1 cycle with LATENCY=4 -> no Ack ever. Then write 0x30 with 0x55 and ByteEnable=4'hF -> read of 0x30 returns 0x00000055, confirming the aborted request left no stale data or ack.
4. Back-to-back: hold ReadEnable high across Ack for two reads, 0x10 then 0x14 -> Acks separated by LATENCY+1 cycles, each with the correct data.
5. Reset mid-write: issue write to 0x40 with 0x12345678, pull RST low during WAIT -> Ack=0 next cycle, ReadData=0. A later read of 0x40 returns the pre-write contents.
6. With DMEM_RANDOM_WAIT_EN, 8 consecutive reads -> each Ack latency within LATENCY..LATENCY+3, and the latency sequence is identical across two runs that both start from reset.
